// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO bus initiators.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mmio_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } dma_state_t;

    localparam logic DMA_COPY = 1'b0;
    localparam logic DMA_FILL = 1'b1;

    // Memory-mapped IO registers on the data bus.
    localparam logic [31:0] MMIO_HEX_ADDR = 32'h0000_0400;
    localparam logic [31:0] MMIO_SW_ADDR  = 32'h0000_0404;

endpackage

// File: rtl/dma_addr_gen.sv
// Word index counter and source/destination address pointers for the DMA.
// Latency: addresses valid the cycle after load; each advance steps them by one word.
// Backpressure: holds its position whenever advance is low (bus not granted).
//
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   load             capture src/dst/len and clear the word index
//   advance          one word has been written; step index and pointers
//   src, dst, len    transfer parameters presented with load
//   src_addr         current source word address
//   dst_addr         current destination word address
//   last             current word is the final one of the transfer
module dma_addr_gen #(
    parameter int          LEN_W     = 16,
    parameter logic [31:0] ADDR_STEP = 32'd1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             advance,
    input  logic [31:0]      src,
    input  logic [31:0]      dst,
    input  logic [LEN_W-1:0] len,
    output logic [31:0]      src_addr,
    output logic [31:0]      dst_addr,
    output logic             last
);

    logic [31:0]      src_ptr;
    logic [31:0]      dst_ptr;
    logic [LEN_W-1:0] idx;
    logic [LEN_W-1:0] len_q;

    // Running pointers equal base + idx*ADDR_STEP modulo 2^32 without a
    // multiplier; the wrap past 32'hFFFFFFFF falls out of the 32-bit add.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_ptr <= '0;
            dst_ptr <= '0;
            idx     <= '0;
            len_q   <= '0;
        end else if (load) begin
            src_ptr <= src;
            dst_ptr <= dst;
            idx     <= '0;
            len_q   <= len;
        end else if (advance) begin
            src_ptr <= src_ptr + ADDR_STEP;
            dst_ptr <= dst_ptr + ADDR_STEP;
            idx     <= idx + 1'b1;
        end
    end

    assign src_addr = src_ptr;
    assign dst_addr = dst_ptr;

    // Compared one bit wider so idx+1 cannot wrap, even at the largest length.
    assign last = (({1'b0, idx} + {{LEN_W{1'b0}}, 1'b1}) == {1'b0, len_q});

endmodule

// File: rtl/mmio_dma.sv
// Bus-initiator DMA: copies a word block (src->dst) or fills dst with a constant.
// Latency: first strobe the cycle after start; COPY 2N granted cycles, FILL N, then one DONE cycle.
// Backpressure: grant=0 stalls the current READ/WRITE with strobes low; nothing advances.
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   start, mode, src, dst, len, fill_value   transfer request, sampled only in IDLE
//   grant                       bus owned by the DMA this cycle
//   bus_req                     DMA wants the bus (READ/WRITE)
//   memread, memwrite, addr, writedata, readdata   MMIO data bus (readdata combinational)
//   busy                        transfer in progress (READ/WRITE/DONE)
//   done                        one-cycle completion pulse
module mmio_dma import mmio_pkg::*; #(
    parameter int          LEN_W     = 16,
    parameter logic [31:0] ADDR_STEP = 32'd1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [31:0]      src,
    input  logic [31:0]      dst,
    input  logic [LEN_W-1:0] len,
    input  logic [31:0]      fill_value,
    input  logic             grant,
    output logic             bus_req,
    output logic             memread,
    output logic             memwrite,
    output logic [31:0]      addr,
    output logic [31:0]      writedata,
    input  logic [31:0]      readdata,
    output logic             busy,
    output logic             done
);

    dma_state_t  state_q;
    dma_state_t  state_n;
    logic        mode_q;
    logic [31:0] fill_q;
    logic [31:0] data_buf;

    logic        load;
    logic        advance;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic        last;

    dma_addr_gen #(
        .LEN_W     (LEN_W),
        .ADDR_STEP (ADDR_STEP)
    ) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .advance  (advance),
        .src      (src),
        .dst      (dst),
        .len      (len),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .last     (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mode_q   <= DMA_COPY;
            fill_q   <= '0;
            data_buf <= '0;
        end else begin
            state_q <= state_n;
            if (load) begin
                mode_q <= mode;
                fill_q <= fill_value;
            end
            // readdata is only meaningful while our read strobe is on the bus.
            if (state_q == READ && grant) begin
                data_buf <= readdata;
            end
        end
    end

    always_comb begin
        state_n   = state_q;
        bus_req   = 1'b0;
        memread   = 1'b0;
        memwrite  = 1'b0;
        addr      = '0;
        writedata = '0;
        load      = 1'b0;
        advance   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if (len == '0) begin
                        state_n = DONE;
                    end else if (mode == DMA_FILL) begin
                        state_n = WRITE;
                    end else begin
                        state_n = READ;
                    end
                end
            end
            READ: begin
                bus_req = 1'b1;
                if (grant) begin
                    memread = 1'b1;
                    addr    = src_addr;
                    state_n = WRITE;
                end
            end
            WRITE: begin
                bus_req = 1'b1;
                if (grant) begin
                    memwrite  = 1'b1;
                    addr      = dst_addr;
                    writedata = (mode_q == DMA_FILL) ? fill_q : data_buf;
                    advance   = 1'b1;
                    if (last) begin
                        state_n = DONE;
                    end else if (mode_q == DMA_COPY) begin
                        state_n = READ;
                    end else begin
                        state_n = WRITE;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule
